// File: rtl/muldiv_seq.sv
// Iterative MIPS mult/multu/div/divu sequencer owning the HI/LO registers.
// One shift/add-subtract step per cycle, sign fixup in a final cycle, single-cycle mthi/mtlo.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int         CW     = $clog2(WIDTH);
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc, acc_step;
  logic [WIDTH-1:0]   opnd, rs_orig;
  logic               op_div, div_zero, sign_q, sign_r;

  logic               is_muldiv, is_signed, accept;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign accept    = (state == IDLE) && start && !flush && is_muldiv;
  assign rs_abs    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // acc holds {carry/remainder (WIDTH+1), multiplier/quotient (WIDTH)}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_step = acc;
    mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = rem_sh - {1'b0, opnd};
    if (!op_div)          acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    else if (trial[WIDTH]) acc_step = {rem_sh, acc[WIDTH-2:0], 1'b0};
    else                  acc_step = {trial, acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod   = sign_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        res_hi = rs_orig;
        res_lo = '1;
      end else begin
        res_hi = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_lo = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = CALC;
        CALC:    if (cnt == LAST) state_nxt = FIXUP;
        FIXUP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      rs_orig  <= '0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && funct == F_MTHI) hi <= rs_val;
            if (start && funct == F_MTLO) lo <= rs_val;
            if (accept) begin
              cnt      <= '0;
              op_div   <= funct[1];
              sign_q   <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              sign_r   <= is_signed & rs_val[WIDTH-1];
              div_zero <= funct[1] && (rt_val == '0);
              rs_orig  <= rs_val;
              opnd     <= funct[1] ? rt_abs : rs_abs;
              acc      <= {{(WIDTH+1){1'b0}}, (funct[1] ? rs_abs : rt_abs)};
            end
          end
          CALC: begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
          FIXUP: begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed HI/LO results, busy length,
// done pulse, flush, ignored starts, and asynchronous reset.
module tb_muldiv_seq;

  localparam int         W     = 32;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle; returns at the first sample point after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts remaining busy cycles, then checks the done pulse and HI/LO.
  task automatic finish_op(input string tag, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input int skipped);
    int n = skipped;
    int early_done = 0;
    while (busy && n < 100) begin
      n++;
      if (done) early_done++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, W'(n), W'(W + 1));
    check({tag, " done_while_busy"}, W'(early_done), '0);
    check({tag, " done_pulse"}, W'(done), W'(1));
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " done_single"}, W'(done), '0);
  endtask

  initial begin
    #1;
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);

    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    finish_op("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

    issue(DIVU, 32'd100, 32'd7);
    finish_op("divu_100by7", 32'h0000_0002, 32'h0000_000E, 0);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 0);

    issue(DIV, 32'h1234_5678, 32'h0);
    finish_op("div_by0", 32'h1234_5678, 32'hFFFF_FFFF, 0);

    issue(DIVU, 32'h1234_5678, 32'h0);
    finish_op("divu_by0", 32'h1234_5678, 32'hFFFF_FFFF, 0);

    issue(DIV, 32'h8000_0001, 32'h0);
    finish_op("div_neg_by0", 32'h8000_0001, 32'hFFFF_FFFF, 0);

    // mthi is single-cycle and leaves busy/done low.
    issue(MTHI, 32'hAAAA_0000, 32'h0);
    check("mthi hi", hi, 32'hAAAA_0000);
    check("mthi lo", lo, 32'hFFFF_FFFF);
    check("mthi busy", W'(busy), '0);
    check("mthi done", W'(done), '0);

    // Flush mid-CALC: no write, no done.
    issue(MULTU, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    check("flush pre busy", W'(busy), W'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", W'(busy), '0);
    check("flush done", W'(done), '0);
    check("flush hi", hi, 32'hAAAA_0000);
    check("flush lo", lo, 32'hFFFF_FFFF);
    @(negedge clk);
    check("flush done_after", W'(done), '0);

    issue(MULTU, 32'd3, 32'd4);
    finish_op("multu_3x4", 32'h0, 32'd12, 0);

    // start+flush together: flush wins for mul/div and mtlo alike.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = MULTU; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    funct = MTLO; rs_val = 32'h55;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush busy", W'(busy), '0);
    check("start_flush lo", lo, 32'd12);
    @(negedge clk);
    check("start_flush busy_after", W'(busy), '0);
    check("start_flush done", W'(done), '0);

    // Unrecognized funct is ignored.
    start = 1'b1; funct = 6'b100000; rs_val = 32'h77; rt_val = 32'h11;
    @(negedge clk);
    start = 1'b0;
    check("bad_funct busy", W'(busy), '0);
    check("bad_funct hi", hi, 32'h0);
    check("bad_funct lo", lo, 32'd12);

    // Starts while busy (multu and mthi) are dropped.
    issue(MULTU, 32'd5, 32'd6);
    start = 1'b1; funct = MULTU; rs_val = 32'd7; rt_val = 32'd7;
    @(negedge clk);
    funct = MTHI; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    finish_op("multu_5x6_busy_start", 32'h0, 32'd30, 2);

    // Flush while in FIXUP suppresses the HI/LO write and done.
    issue(MULTU, 32'd2, 32'd2);
    repeat (32) @(negedge clk);
    check("fixup_flush pre busy", W'(busy), W'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fixup_flush busy", W'(busy), '0);
    check("fixup_flush done", W'(done), '0);
    check("fixup_flush lo", lo, 32'd30);

    // Asynchronous reset mid-CALC.
    issue(MULTU, 32'd7, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst hi", hi, '0);
    check("async_rst lo", lo, '0);
    check("async_rst busy", W'(busy), '0);
    check("async_rst done", W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(MULTU, 32'd7, 32'd7);
    finish_op("multu_after_rst", 32'h0, 32'd49, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the pipeline's EX stage. It executes MIPS mult, multu, div and divu over 32 cycles on a shared shift/add-subtract datapath and owns the architectural HI/LO registers. While an operation is in flight it raises busy, which the hazard logic uses to stall; it also services mthi/mtlo writes in a single cycle.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  EX-stage request valid. The command is funct.
- funct  input  6  011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo; all other codes are ignored.
- rs_val  input  WIDTH  multiplicand, dividend, or mthi/mtlo data.
- rt_val  input  WIDTH  multiplier or divisor.
- flush  input  1  abort any in-flight operation.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation
- States:
  - IDLE: accepts commands.
  - CALC: one iteration per cycle; a 5-bit counter counts 0..WIDTH-1.
  - FIXUP: sign correction, HI/LO write, done.
- Transitions:
  - IDLE → CALC: start is high, funct is mul/div, and flush is low.
  - CALC → FIXUP: after the iteration with counter == WIDTH-1.
  - FIXUP → IDLE: unconditional.
  - Any state → IDLE: flush is high.
- Capture at accept:
  - The operation is latched as signed (mult/div) or unsigned.
  - Operand magnitudes are captured; signed operands are replaced by their two's-complement absolute values.
  - Result signs are latched:
    - product sign = rs[MSB]^rt[MSB];
    - quotient sign = rs[MSB]^rt[MSB];
    - remainder sign = rs[MSB].
- Multiply:
  - Radix-2 shift-add on a 2·WIDTH accumulator; the upper half is WIDTH+1 bits to hold the carry.
  - FIXUP negates the 2·WIDTH product if its sign is set, then writes HI = upper half and LO = lower half.
- Divide:
  - Restoring division: shift {rem, quo} left, trial-subtract the divisor, keep the result if it is non-negative, and set the quotient bit.
  - FIXUP writes LO = quotient and HI = remainder, each negated per its latched sign.
  - -2^31 / -1 gives LO = 0x80000000 and HI = 0 with no exception.
- Divide by zero:
  - The full latency is still taken.
  - Result is LO = all-ones and HI = original rs_val, regardless of signedness.
- mthi/mtlo:
  - Accepted only in IDLE with flush low.
  - Writes hi or lo at that edge.
  - busy stays low and done is not asserted.
- start while busy is ignored; the pipeline must hold the instruction using busy.
- Unrecognized funct with start high: no state change.
- flush:
  - Returns to IDLE at the next edge.
  - HI/LO keep their prior values and done is not asserted.
  - Flush in FIXUP suppresses the write.
  - flush and start in the same cycle: flush wins and start is dropped.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, state IDLE, counter 0.
- Accept edge E0: busy rises after E0.
- CALC occupies edges E1..E32; the state is FIXUP after E32.
- At E33, HI/LO update, state returns to IDLE, busy falls, and done is high for the single cycle after E33.
- busy is high for exactly WIDTH+1 cycles.
- A new start may be accepted at E34, the first edge with busy low.
- hi/lo are registered outputs; the new value is readable by mfhi/mflo in the cycle after E33.
- mthi/mtlo: zero-bubble, with the value visible in the cycle after the accept edge.
- done is registered and never asserted in two consecutive cycles.

## Test plan
- multu with rs = rt = 0xFFFFFFFF → after WIDTH+1 busy cycles, hi = 0xFFFFFFFE, lo = 0x00000001, and one done pulse.
- mult with rs = 0xFFFFFFFD (-3), rt = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Then div with rs = 0xFFFFFFF9 (-7), rt = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu 100/7 → lo = 0x0000000E, hi = 0x00000002. div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- div and divu by zero with rs = 0x12345678 → lo = 0xFFFFFFFF, hi = 0x12345678, busy for WIDTH+1 cycles, one done pulse.
- Preload hi = 0xAAAA0000 via mthi. Start multu 3×4, assert flush at cycle 10 → busy falls next edge, no done, hi stays 0xAAAA0000, lo unchanged. Then multu 3×4 → lo = 12, hi = 0.
- Start a second multu while busy, and assert start+flush together → both ignored. Assert rst_n low mid-CALC → hi = lo = 0, busy = 0 immediately, asynchronously.
